instbuffer_ctrl: RTL and testbench

//  Circular instruction buffer and pointer controller between the fetch stage and seg_issue.

---
 rtl/instbuffer_ctrl.sv | 96 +++++++++
 tb/tb_instbuffer_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/instbuffer_ctrl.sv
// Circular instruction buffer between fetch and issue: 0-2 pushes and 0-2 pops per cycle, flush on redirect.
// Optional performance counters are enabled by defining INSTBUFFER_PERF_EN.
module instbuffer_ctrl #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned BUS_W = 131
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic [1:0]                 fetch_num_i,
  input  logic [BUS_W-1:0]           fetch_inst1_bus_i,
  input  logic [BUS_W-1:0]           fetch_inst2_bus_i,
  output logic                       fetch_allowin_o,
  input  logic [1:0]                 issue_mode_i,
  output logic [1:0]                 instbuffer_count_o,
  output logic [BUS_W-1:0]           inst1_bus_o,
  output logic [BUS_W-1:0]           inst2_bus_o,
  output logic [$clog2(DEPTH):0]     occupancy_o,
`ifdef INSTBUFFER_PERF_EN
  output logic [31:0]                perf_empty_cyc_o,
  output logic [31:0]                perf_dual_issue_o,
`endif
  output logic                       overflow_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned OW = AW + 1;

  logic [BUS_W-1:0] mem [DEPTH];
  logic [AW-1:0]    head, tail, head_p1, tail_p1;
  logic [OW-1:0]    occ, free;
  logic [1:0]       npush, npop_req, npop, npush_eff;
  logic             overflow;

  assign head_p1 = head + AW'(1);
  assign tail_p1 = tail + AW'(1);

  always_comb begin
    npush    = (fetch_num_i == 2'd0) ? 2'd0 : (fetch_num_i == 2'd1) ? 2'd1 : 2'd2;
    npop_req = 2'd0;
    case (issue_mode_i)
      2'b01:   npop_req = 2'd1;
      2'b10:   npop_req = 2'd2;
      default: npop_req = 2'd0;
    endcase
    // both clamps only bind when the bound is below 2, so the low bits carry it exactly
    npop      = (OW'(npop_req) > occ) ? occ[1:0] : npop_req;
    free      = OW'(DEPTH) - occ + OW'(npop);
    npush_eff = (OW'(npush) > free) ? free[1:0] : npush;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      occ      <= '0;
      overflow <= 1'b0;
    end else if (flush_i) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else begin
      head <= head + AW'(npop);
      tail <= tail + AW'(npush_eff);
      occ  <= occ + OW'(npush_eff) - OW'(npop);
      if (npush_eff != npush) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush_i) begin
      if (npush_eff != 2'd0) mem[tail]    <= fetch_inst1_bus_i;
      if (npush_eff == 2'd2) mem[tail_p1] <= fetch_inst2_bus_i;
    end
  end

`ifdef INSTBUFFER_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_empty_cyc_o  <= '0;
      perf_dual_issue_o <= '0;
    end else begin
      if (occ == '0) perf_empty_cyc_o <= perf_empty_cyc_o + 32'd1;
      if (!flush_i && npop == 2'd2) perf_dual_issue_o <= perf_dual_issue_o + 32'd1;
    end
  end
`endif

  assign fetch_allowin_o    = (OW'(DEPTH) - occ) >= OW'(2);
  assign instbuffer_count_o = (occ == '0) ? 2'b00 : (occ == OW'(1)) ? 2'b01 : 2'b10;
  assign inst1_bus_o        = (occ >= OW'(1)) ? mem[head]    : '0;
  assign inst2_bus_o        = (occ >= OW'(2)) ? mem[head_p1] : '0;
  assign occupancy_o        = occ;
  assign overflow_o         = overflow;

endmodule

// File: tb/tb_instbuffer_ctrl.sv
// Scoreboard bench for instbuffer_ctrl: a queue holds the expected buffer contents in order;
// every cycle the DUT outputs are compared against the queue head before the next transfer.
module tb_instbuffer_ctrl;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned BUS_W = 131;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush_i = 1'b0;
  logic [1:0]       fetch_num_i = 2'd0;
  logic [BUS_W-1:0] fetch_inst1_bus_i = '0;
  logic [BUS_W-1:0] fetch_inst2_bus_i = '0;
  logic             fetch_allowin_o;
  logic [1:0]       issue_mode_i = 2'd0;
  logic [1:0]       instbuffer_count_o;
  logic [BUS_W-1:0] inst1_bus_o, inst2_bus_o;
  logic [4:0]       occupancy_o;
  logic             overflow_o;
`ifdef INSTBUFFER_PERF_EN
  logic [31:0]      perf_empty_cyc_o, perf_dual_issue_o;
`endif

  instbuffer_ctrl #(.DEPTH(DEPTH), .BUS_W(BUS_W)) dut (
    .clk                (clk),
    .rst                (rst),
    .flush_i            (flush_i),
    .fetch_num_i        (fetch_num_i),
    .fetch_inst1_bus_i  (fetch_inst1_bus_i),
    .fetch_inst2_bus_i  (fetch_inst2_bus_i),
    .fetch_allowin_o    (fetch_allowin_o),
    .issue_mode_i       (issue_mode_i),
    .instbuffer_count_o (instbuffer_count_o),
    .inst1_bus_o        (inst1_bus_o),
    .inst2_bus_o        (inst2_bus_o),
    .occupancy_o        (occupancy_o),
`ifdef INSTBUFFER_PERF_EN
    .perf_empty_cyc_o   (perf_empty_cyc_o),
    .perf_dual_issue_o  (perf_dual_issue_o),
`endif
    .overflow_o         (overflow_o)
  );

  always #5 clk = ~clk;

  logic [BUS_W-1:0] sb[$];
  logic             m_ovf = 1'b0;
  int unsigned      n_checks = 0;
  int unsigned      n_errors = 0;

  task automatic check(input string tag, input logic [BUS_W-1:0] got, input logic [BUS_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [BUS_W-1:0] rnd_bus();
    logic [159:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return t[BUS_W-1:0];
  endfunction

  task automatic check_outputs(input string tag);
    int n;
    n = sb.size();
    check({tag, ".occ"},   BUS_W'(occupancy_o), BUS_W'(n));
    check({tag, ".count"}, BUS_W'(instbuffer_count_o), BUS_W'((n == 0) ? 0 : (n == 1) ? 1 : 2));
    check({tag, ".allow"}, BUS_W'(fetch_allowin_o), BUS_W'((DEPTH - n) >= 2));
    check({tag, ".ovf"},   BUS_W'(overflow_o), BUS_W'(m_ovf));
    check({tag, ".inst1"}, inst1_bus_o, (n >= 1) ? sb[0] : '0);
    check({tag, ".inst2"}, inst2_bus_o, (n >= 2) ? sb[1] : '0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    m_ovf = 1'b0;
  endtask

  // One clock: compare outputs, apply a transfer, then advance the scoreboard.
  task automatic cyc(input string tag, input logic [1:0] fn, input logic [BUS_W-1:0] b1,
                     input logic [BUS_W-1:0] b2, input logic [1:0] mode, input logic fl);
    int n, np, push, free, acc;
    check_outputs(tag);
    fetch_num_i = fn; fetch_inst1_bus_i = b1; fetch_inst2_bus_i = b2;
    issue_mode_i = mode; flush_i = fl;
    @(posedge clk); #1;
    n    = sb.size();
    np   = (mode == 2'b01) ? 1 : (mode == 2'b10) ? 2 : 0;
    if (np > n) np = n;
    push = (fn == 2'd0) ? 0 : (fn == 2'd1) ? 1 : 2;
    free = DEPTH - n + np;
    acc  = (push < free) ? push : free;
    if (fl) sb.delete();
    else begin
      repeat (np) void'(sb.pop_front());
      if (acc >= 1) sb.push_back(b1);
      if (acc >= 2) sb.push_back(b2);
      if (acc < push) m_ovf = 1'b1;
    end
    fetch_num_i = 2'd0; issue_mode_i = 2'd0; flush_i = 1'b0;
  endtask

  logic [BUS_W-1:0] va, vb;

  initial begin
    #1;
    do_reset();
    check_outputs("reset");

    // push two, then dual issue
    va = rnd_bus(); vb = rnd_bus();
    cyc("push2", 2'd2, va, vb, 2'b00, 1'b0);
    check("ab.inst1", inst1_bus_o, va);
    check("ab.inst2", inst2_bus_o, vb);
    cyc("dual", 2'd0, '0, '0, 2'b10, 1'b0);
    check("ab.empty", BUS_W'(instbuffer_count_o), BUS_W'(0));

    // fill to 15, then overflow one entry
    for (int i = 0; i < 7; i++) cyc("fill", 2'd2, rnd_bus(), rnd_bus(), 2'b00, 1'b0);
    cyc("fill1", 2'd1, rnd_bus(), '0, 2'b00, 1'b0);
    check("occ15.allow", BUS_W'(fetch_allowin_o), BUS_W'(0));
    cyc("over", 2'd2, rnd_bus(), rnd_bus(), 2'b00, 1'b0);
    check("over.occ", BUS_W'(occupancy_o), BUS_W'(16));
    check("over.flag", BUS_W'(overflow_o), BUS_W'(1));

    // full: dual pop plus dual push keeps it full, fetch_num 3 behaves as 2
    cyc("fullswap", 2'd3, rnd_bus(), rnd_bus(), 2'b10, 1'b0);
    check("fullswap.occ", BUS_W'(occupancy_o), BUS_W'(16));
    for (int i = 0; i < 9; i++) cyc("drain", 2'd0, '0, '0, 2'b10, 1'b0);
    cyc("mode11", 2'd1, rnd_bus(), '0, 2'b11, 1'b0);
    cyc("dual_on_one", 2'd0, '0, '0, 2'b10, 1'b0);

    // walk tail to slot 15, then push across the wrap
    do_reset();
    for (int i = 0; i < 15; i++) cyc("walk", 2'd1, rnd_bus(), '0, 2'b01, 1'b0);
    va = rnd_bus(); vb = rnd_bus();
    cyc("wrap", 2'd2, va, vb, 2'b00, 1'b0);
    cyc("wrap.pop0", 2'd0, '0, '0, 2'b01, 1'b0);
    check("wrap.x", inst1_bus_o, va);
    cyc("wrap.pop1", 2'd0, '0, '0, 2'b01, 1'b0);
    check("wrap.y", inst1_bus_o, vb);
    cyc("wrap.pop2", 2'd0, '0, '0, 2'b01, 1'b0);

    // flush beats same-cycle push and pop
    cyc("f5a", 2'd2, rnd_bus(), rnd_bus(), 2'b00, 1'b0);
    cyc("f5b", 2'd2, rnd_bus(), rnd_bus(), 2'b00, 1'b0);
    cyc("f5c", 2'd1, rnd_bus(), '0, 2'b00, 1'b0);
    check("f5.occ", BUS_W'(occupancy_o), BUS_W'(5));
    cyc("flush", 2'd2, rnd_bus(), rnd_bus(), 2'b01, 1'b1);
    check("flush.occ", BUS_W'(occupancy_o), BUS_W'(0));
    va = rnd_bus();
    cyc("z", 2'd1, va, '0, 2'b00, 1'b0);
    check("z.inst1", inst1_bus_o, va);

    // random traffic with occasional flush and reset
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      cyc("rand", 2'($urandom_range(0, 3)), rnd_bus(), rnd_bus(),
          2'($urandom_range(0, 3)), ($urandom_range(0, 39) == 0));
    end
    check_outputs("final");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
